// File: rtl/alu_req_arbiter.sv
// Two-requester front end for the shared alu_dut: round-robin grant, one enable pulse per job, latency wait, result return.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no last-grant pointer).
module alu_req_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req0_sel,
  input  logic        req0_shift,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic [2:0]  req1_sel,
  input  logic        req1_shift,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] aluin1,
  output logic [31:0] aluin2,
  output logic [2:0]  operation,
  output logic [2:0]  opselect,
  output logic        enable_arith,
  output logic        enable_shift,
  input  logic [31:0] aluout
);

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_nxt;
  logic        r_id, r_shift;
  logic [31:0] r_a, r_b, r_data;
  logic [2:0]  r_op, r_sel;
  logic [3:0]  r_cnt;
  logic        w_win, w_accept, w_cap;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_win = ~req_valid[0];
`else
  logic r_ptr;  // last granted requester

  always_comb begin
    w_win = req_valid[1];
    if (&req_valid) w_win = ~r_ptr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_ptr <= 1'b1;
    else if (w_accept) r_ptr <= w_win;
  end
`endif

  always_comb begin
    w_nxt        = r_state;
    w_accept     = 1'b0;
    w_cap        = 1'b0;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    enable_arith = 1'b0;
    enable_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        // gate on reset_n so req_ready stays low while reset is held
        if (|req_valid && reset_n) begin
          w_accept  = 1'b1;
          req_ready = w_win ? 2'b10 : 2'b01;
          w_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        enable_shift = r_shift;
        enable_arith = ~r_shift;
        w_nxt        = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_cap = 1'b1;
          w_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = r_id ? 2'b10 : 2'b01;
        if (rsp_ready[r_id]) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_id    <= 1'b0;
      r_shift <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_id    <= w_win;
        r_a     <= w_win ? req1_a     : req0_a;
        r_b     <= w_win ? req1_b     : req0_b;
        r_op    <= w_win ? req1_op    : req0_op;
        r_sel   <= w_win ? req1_sel   : req0_sel;
        r_shift <= w_win ? req1_shift : req0_shift;
      end
      if (r_state == S_ISSUE)     r_cnt <= LAT4;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_cap) r_data <= aluout;
    end
  end

  assign aluin1    = r_a;
  assign aluin2    = r_b;
  assign operation = r_op;
  assign opselect  = r_sel;
  assign rsp_data  = r_data;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Random + directed bench for alu_req_arbiter: two instances (ALU_LAT 1 and 3), each with a one-shot behavioural ALU.
module tb_alu_req_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        rst    [2];
  logic [1:0]  i_val  [2];
  logic [1:0]  i_rrdy [2];
  logic [31:0] i_a    [2][2];
  logic [31:0] i_b    [2][2];
  logic [2:0]  i_op   [2][2];
  logic [2:0]  i_sel  [2][2];
  logic        i_sh   [2][2];

  logic [1:0]  o_rrdy [2];
  logic [1:0]  o_rval [2];
  logic [31:0] o_data [2];
  logic [31:0] o_a1   [2];
  logic [31:0] o_a2   [2];
  logic [2:0]  o_op   [2];
  logic [2:0]  o_sel  [2];
  logic        o_ea   [2];
  logic        o_es   [2];

  int n_chk = 0;
  int n_err = 0;
  int last [2];

  logic [31:0] pa [2], pb [2];
  logic [2:0]  pop [2], psel [2];
  logic        psh [2];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [2:0] sel, input logic sh);
    logic [4:0] s;
    s = b[4:0];
    if (sh) return ((a << s) | (a >> (6'd32 - {1'b0, s}))) ^ {26'b0, op, sel};
    return (a + b) ^ {op, sel, 26'b0};
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // round-robin: both valid -> the one not granted last; otherwise the only valid one
  function automatic int pick(input int k, input logic [1:0] v);
    if (v == 2'b11) return FIXED ? 0 : 1 - last[k];
    return v[0] ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] aout;
    logic        en_s = 1'b0;
    logic        sh_s = 1'b0;
    logic [31:0] a_s, b_s, val;
    logic [2:0]  op_s, sel_s;
    int          cyc = 0;
    int          due = -1;

    alu_req_arbiter #(.ALU_LAT(L)) u_dut (
      .clock(clock), .reset_n(rst[g]),
      .req_valid(i_val[g]), .req_ready(o_rrdy[g]),
      .req0_a(i_a[g][0]), .req0_b(i_b[g][0]), .req0_op(i_op[g][0]),
      .req0_sel(i_sel[g][0]), .req0_shift(i_sh[g][0]),
      .req1_a(i_a[g][1]), .req1_b(i_b[g][1]), .req1_op(i_op[g][1]),
      .req1_sel(i_sel[g][1]), .req1_shift(i_sh[g][1]),
      .rsp_valid(o_rval[g]), .rsp_ready(i_rrdy[g]), .rsp_data(o_data[g]),
      .aluin1(o_a1[g]), .aluin2(o_a2[g]), .operation(o_op[g]), .opselect(o_sel[g]),
      .enable_arith(o_ea[g]), .enable_shift(o_es[g]), .aluout(aout)
    );

    always @(negedge clock) begin
      en_s  = o_ea[g] | o_es[g];
      sh_s  = o_es[g];
      a_s   = o_a1[g];
      b_s   = o_a2[g];
      op_s  = o_op[g];
      sel_s = o_sel[g];
    end

    // result valid only in the single cycle before the L-th edge after the enable edge
    always @(posedge clock) begin
      cyc++;
      if (en_s) begin
        due = cyc + L - 1;
        val = alu_f(a_s, b_s, op_s, sel_s, sh_s);
      end
      #1;
      aout = (due == cyc) ? val : $urandom;
    end
  end

  task automatic rnd_payload();
    for (int r = 0; r < 2; r++) begin
      pa[r]   = $urandom;
      pb[r]   = $urandom;
      pop[r]  = 3'($urandom);
      psel[r] = 3'($urandom);
      psh[r]  = 1'($urandom);
    end
  endtask

  task automatic chk_zero(input int k);
    chk("rst_rrdy", o_rrdy[k], 0);
    chk("rst_rval", o_rval[k], 0);
    chk("rst_data", o_data[k], 0);
    chk("rst_a1",   o_a1[k],   0);
    chk("rst_a2",   o_a2[k],   0);
    chk("rst_op",   o_op[k],   0);
    chk("rst_sel",  o_sel[k],  0);
    chk("rst_en",   {o_ea[k], o_es[k]}, 0);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      i_val[k]  = 2'b00;
      i_rrdy[k] = 2'($urandom);
      @(negedge clock);
      chk("idle_rval", o_rval[k], 0);
      chk("idle_rrdy", o_rrdy[k], 0);
      chk("idle_en",   {o_ea[k], o_es[k]}, 0);
    end
  endtask

  // one transaction: accept cycle, then cycle c=1.. after the accept edge; abort_at>0 resets the DUT at cycle c
  task automatic txn(input int k, input logic [1:0] v, input int hold, input int abort_at);
    int          L, w, c_end;
    logic [31:0] exp, ea, eb;
    logic [2:0]  eop, esel;
    logic        esh;
    L     = lat(k);
    c_end = 2 + L + hold;
    @(posedge clock); #1;
    for (int r = 0; r < 2; r++) begin
      i_a[k][r] = pa[r]; i_b[k][r] = pb[r]; i_op[k][r] = pop[r];
      i_sel[k][r] = psel[r]; i_sh[k][r] = psh[r];
    end
    i_val[k]  = v;
    i_rrdy[k] = 2'b00;
    @(negedge clock);
    w = pick(k, v);
    chk("accept_rrdy", o_rrdy[k], 32'(1 << w));
    chk("accept_rval", o_rval[k], 0);
    chk("accept_en",   {o_ea[k], o_es[k]}, 0);
    ea = pa[w]; eb = pb[w]; eop = pop[w]; esel = psel[w]; esh = psh[w];
    exp = alu_f(ea, eb, eop, esel, esh);
    last[k] = w;
    for (int c = 1; c <= c_end; c++) begin
      @(posedge clock); #1;
      for (int r = 0; r < 2; r++) begin
        i_a[k][r] = $urandom; i_b[k][r] = $urandom; i_op[k][r] = 3'($urandom);
        i_sel[k][r] = 3'($urandom); i_sh[k][r] = 1'($urandom);
      end
      i_val[k]  = 2'($urandom);
      i_rrdy[k] = (c == c_end) ? (2'(1 << w) | 2'($urandom)) : (2'($urandom) & ~2'(1 << w));
      if (c == abort_at) begin
        rst[k]   = 1'b0;
        i_val[k] = 2'b11;
        #1;
        chk_zero(k);
        @(posedge clock); #1;
        chk_zero(k);
        rst[k]    = 1'b1;
        i_val[k]  = 2'b00;
        i_rrdy[k] = 2'b00;
        last[k]   = 1;
        return;
      end
      @(negedge clock);
      chk("busy_rrdy", o_rrdy[k], 0);
      chk("en_arith",  o_ea[k], 32'((c == 1) && !esh));
      chk("en_shift",  o_es[k], 32'((c == 1) && esh));
      if (c <= L + 1) begin
        chk("aluin1",    o_a1[k],  ea);
        chk("aluin2",    o_a2[k],  eb);
        chk("operation", o_op[k],  eop);
        chk("opselect",  o_sel[k], esel);
      end
      chk("rsp_valid", o_rval[k], (c >= 2 + L) ? 32'(1 << w) : 32'd0);
      if (c >= 2 + L) chk("rsp_data", o_data[k], exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      last[k]   = 1;
      rst[k]    = 1'b1;
      i_val[k]  = 2'b00;
      i_rrdy[k] = 2'b00;
      for (int r = 0; r < 2; r++) begin
        i_a[k][r] = '0; i_b[k][r] = '0; i_op[k][r] = '0; i_sel[k][r] = '0; i_sh[k][r] = 1'b0;
      end
    end
    rnd_payload();
    #2;
    for (int k = 0; k < 2; k++) begin
      rst[k]   = 1'b0;
      i_val[k] = 2'b11;
    end
    @(negedge clock);
    chk_zero(0);
    chk_zero(1);
    @(posedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      rst[k]   = 1'b1;
      i_val[k] = 2'b00;
    end

    // ALU_LAT = 1
    for (int i = 0; i < 4; i++) begin
      rnd_payload();
      txn(0, 2'b11, 0, 0);
    end
    rnd_payload();
    pa[0] = 32'd5; pb[0] = 32'd7; pop[0] = 3'd0; psel[0] = 3'd0; psh[0] = 1'b0;
    txn(0, 2'b01, 0, 0);
    rnd_payload();
    pa[1] = 32'h8000_0001; pb[1] = 32'd1; psh[1] = 1'b1;
    txn(0, 2'b10, 0, 0);
    rnd_payload();
    txn(0, 2'($urandom_range(1, 3)), 10, 0);
    repeat (20) begin
      rnd_payload();
      txn(0, 2'($urandom_range(1, 3)), $urandom_range(0, 3), 0);
    end
    idle(0, 2);

    // ALU_LAT = 3
    rnd_payload();
    txn(1, 2'b11, 0, 0);
    rnd_payload();
    txn(1, 2'b01, 0, 2);
    idle(1, 6);
    rnd_payload();
    txn(1, 2'b11, 0, 0);
    repeat (15) begin
      rnd_payload();
      txn(1, 2'($urandom_range(1, 3)), $urandom_range(0, 4), 0);
    end
    idle(1, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
